proc_control_unit: RTL
======================

# proc_control_unit

Control unit for the 16-bit processor: it fetches instructions from a synchronous instruction ROM, decodes them, and sequences the datapath. It drives every datapath control input (data-memory address and write, register-file addresses, write enable, write-source select, ALU select) through a Moore FSM with a program counter and an instruction register. It sits directly upstream of the datapath; the datapath's A, B and ALU outputs are not consumed here.

## Interface
Parameters:
- PC_WIDTH, 7, program-counter and ROM address width (128 instructions)

Ports:
- Clk  in  1  system clock, rising-edge
- ResetN  in  1  asynchronous, active-low reset
- IR_Data  in  16  instruction ROM read data; registered ROM, valid one cycle after PC_Rd
- PC_Addr  out  PC_WIDTH  instruction ROM address; equals the PC
- PC_Rd  out  1  instruction ROM read enable
- D_Addr  out  8  data-memory address
- D_wr  out  1  data-memory write enable; the datapath stores register A to memory
- RF_s  out  1  register-file write source: 1 = memory, 0 = ALU
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_addr  out  4  register-file A read address
- RF_Rb_addr  out  4  register-file B read address
- Alu_s0  out  3  ALU function select
- IR_Out  out  16  instruction register (debug/display)
- State_Out  out  4  current FSM state encoding (debug/display)
- Halted  out  1  high while in HALT

## Operation
- Opcode is IR[15:12]:
  - 0000 NOOP.
  - 0001 STORE: mem[IR[11:4]] = R[IR[3:0]].
  - 0010 LOAD: R[IR[3:0]] = mem[IR[11:4]].
  - 0011 ADD: R[IR[3:0]] = R[IR[11:8]] + R[IR[7:4]].
  - 0100 SUB: same fields, A − B.
  - 0101 HALT.
  - 0110–1111 are executed as NOOP.
- ALU codes: 3'd0 pass A, 3'd1 add, 3'd2 sub.
- FSM states: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- INIT: PC cleared to 0, then go to FETCH.
- FETCH: PC_Rd=1, then go to DECODE.
- DECODE: branch on IR_Data[15:12]. At the end of the cycle, IR <= IR_Data and PC <= PC+1.
- NOOP: go to FETCH.
- LOAD_A: D_Addr=IR[11:4], then go to LOAD_B.
- LOAD_B: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1, then go to FETCH.
- STORE: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1, then go to FETCH.
- ADD / SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, Alu_s0=1 or 2 respectively, then go to FETCH.
- HALT: absorbing state. Halted=1; PC and IR frozen; PC_Rd=0. Only ResetN exits it.
- Any control output not listed for a state is 0 in that state, including address fields.
- PC increments modulo 2^PC_WIDTH: address 127 wraps to 0 with no flag.

## Timing
- Reset: ResetN low forces the following immediately, without waiting for a clock edge, including mid-instruction:
  - state INIT; PC=0; IR=0.
  - all outputs 0: PC_Addr, PC_Rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0, IR_Out, Halted.
  - State_Out = INIT encoding (0).
- Control outputs are Moore outputs, decoded combinationally from the state register and IR only. They never depend on IR_Data, with one exception: DECODE next-state logic uses IR_Data.
- Cycles per instruction:
  - NOOP, STORE, ADD, SUB, illegal opcodes: 3 (FETCH, DECODE, EXEC).
  - LOAD: 4, because data memory has a 1-cycle synchronous read.
  - HALT: 2 cycles, then stays in HALT.
- First FETCH occurs in the 2nd cycle after ResetN deasserts (INIT lasts 1 cycle).
- Every write enable (D_wr, RF_W_en) is asserted for exactly one cycle per instruction.

## Structure
- Package proc_pkg holds:
  - opcode enum (NOOP, STORE, LOAD, ADD, SUB, HALT).
  - FSM state enum: 4-bit, INIT=0, FETCH=1, DECODE=2, LOAD_A=3, LOAD_B=4, STORE=5, ADD=6, SUB=7, HALT=8, NOOP=9.
  - ALU select constants.
  - instruction field bit-range constants.
- Sub-module program_counter holds the counter and exposes:
  - Clk, ResetN
  - Clr (INIT)
  - Inc (DECODE)
  - Count [PC_WIDTH-1:0]
- IR and FSM live in the top module.

## Test plan
- Reset: ResetN low mid-run → all outputs 0 and State_Out=0 before the next edge. Release → 1 cycle INIT, then FETCH with PC_Addr=0, PC_Rd=1.
- LOAD 16'h21B5 at address 0:
  - D_Addr=8'h1B in LOAD_A and LOAD_B.
  - RF_s=1, RF_W_en=1, RF_W_addr=5 only in LOAD_B.
  - Next FETCH has PC_Addr=1, 4 cycles after the previous FETCH.
- ADD 16'h3123 → one cycle with Ra=1, Rb=2, W=3, Alu_s0=1, RF_W_en=1, RF_s=0, D_wr=0. SUB 16'h4123 → same fields with Alu_s0=2.
- STORE 16'h1092 → one cycle with D_Addr=8'h09, RF_Ra_addr=2, D_wr=1, RF_W_en=0.
- HALT 16'h5000 at address 3 → Halted=1 and PC_Addr=4 held for 20+ cycles, PC_Rd=0. ResetN pulse → restart at address 0.
- ROM filled with 16'hF000 (illegal opcode) → each executes as a 3-cycle NOOP with no enables asserted. After the address-127 fetch, PC_Addr wraps to 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the 16-bit processor control unit:
// opcodes, FSM state encoding, ALU selects and instruction field positions.
package proc_pkg;

  localparam int unsigned INSTR_WIDTH     = 16;
  localparam int unsigned OPC_WIDTH       = 4;
  localparam int unsigned REG_ADDR_WIDTH  = 4;
  localparam int unsigned DMEM_ADDR_WIDTH = 8;
  localparam int unsigned ALU_SEL_WIDTH   = 3;
  localparam int unsigned STATE_WIDTH     = 4;

  // Instruction field bit ranges
  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 12;
  localparam int unsigned DADDR_MSB = 11;
  localparam int unsigned DADDR_LSB = 4;
  localparam int unsigned RA_MSB    = 11;
  localparam int unsigned RA_LSB    = 8;
  localparam int unsigned RB_MSB    = 7;
  localparam int unsigned RB_LSB    = 4;
  localparam int unsigned RD_MSB    = 3;
  localparam int unsigned RD_LSB    = 0;

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_e;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8,
    S_NOOP   = 4'd9
  } state_e;

  localparam logic [ALU_SEL_WIDTH-1:0] ALU_PASS_A = 3'd0;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_ADD    = 3'd1;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SUB    = 3'd2;

  // Datapath control bundle driven each cycle by the FSM
  typedef struct packed {
    logic [DMEM_ADDR_WIDTH-1:0] d_addr;
    logic                       d_wr;
    logic                       rf_s;
    logic [REG_ADDR_WIDTH-1:0]  rf_w_addr;
    logic                       rf_w_en;
    logic [REG_ADDR_WIDTH-1:0]  rf_ra_addr;
    logic [REG_ADDR_WIDTH-1:0]  rf_rb_addr;
    logic [ALU_SEL_WIDTH-1:0]   alu_s;
  } ctrl_t;

  function automatic logic [OPC_WIDTH-1:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [DMEM_ADDR_WIDTH-1:0] daddr_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[DADDR_MSB:DADDR_LSB];
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] ra_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[RA_MSB:RA_LSB];
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] rb_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[RB_MSB:RB_LSB];
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] rd_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/program_counter.sv
// Instruction-address counter: synchronous clear and increment, wraps
// modulo 2^PC_WIDTH.
module program_counter #(
  parameter int unsigned PC_WIDTH = 7
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic                Clr,
  input  logic                Inc,
  output logic [PC_WIDTH-1:0] Count
);

  // Clear has priority over increment; overflow wraps silently
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc) begin
      Count <= Count + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Control unit: fetches from a registered instruction ROM, decodes and
// sequences the datapath through a Moore FSM with PC and IR.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 7
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  input  logic [INSTR_WIDTH-1:0]     IR_Data,
  output logic [PC_WIDTH-1:0]        PC_Addr,
  output logic                       PC_Rd,
  output logic [DMEM_ADDR_WIDTH-1:0] D_Addr,
  output logic                       D_wr,
  output logic                       RF_s,
  output logic [REG_ADDR_WIDTH-1:0]  RF_W_addr,
  output logic                       RF_W_en,
  output logic [REG_ADDR_WIDTH-1:0]  RF_Ra_addr,
  output logic [REG_ADDR_WIDTH-1:0]  RF_Rb_addr,
  output logic [ALU_SEL_WIDTH-1:0]   Alu_s0,
  output logic [INSTR_WIDTH-1:0]     IR_Out,
  output logic [STATE_WIDTH-1:0]     State_Out,
  output logic                       Halted
);

  state_e                 state;
  state_e                 state_nxt;
  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]    pc;
  logic                   pc_clr;
  logic                   pc_inc;
  logic                   pc_rd;
  ctrl_t                  ctrl;

  program_counter #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Clr    (pc_clr),
    .Inc    (pc_inc),
    .Count  (pc)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // IR captures the ROM word at the end of DECODE and holds otherwise
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ir <= '0;
    end else if (state == S_DECODE) begin
      ir <= IR_Data;
    end
  end

  // Next state and Moore controls; only DECODE's branch looks at IR_Data
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pc_rd     = 1'b0;
    case (state)
      S_INIT: begin
        pc_clr    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        pc_rd     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        pc_inc = 1'b1;
        case (opcode_of(IR_Data))
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_HALT:  state_nxt = S_HALT;
          default:  state_nxt = S_NOOP;
        endcase
      end
      S_NOOP: begin
        state_nxt = S_FETCH;
      end
      S_LOAD_A: begin
        ctrl.d_addr = daddr_of(ir);
        state_nxt   = S_LOAD_B;
      end
      S_LOAD_B: begin
        ctrl.d_addr    = daddr_of(ir);
        ctrl.rf_s      = 1'b1;
        ctrl.rf_w_addr = rd_of(ir);
        ctrl.rf_w_en   = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_STORE: begin
        ctrl.d_addr     = daddr_of(ir);
        ctrl.rf_ra_addr = rd_of(ir);
        ctrl.d_wr       = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_ADD, S_SUB: begin
        ctrl.rf_ra_addr = ra_of(ir);
        ctrl.rf_rb_addr = rb_of(ir);
        ctrl.rf_w_addr  = rd_of(ir);
        ctrl.rf_w_en    = 1'b1;
        ctrl.rf_s       = 1'b0;
        ctrl.alu_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        state_nxt       = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  assign PC_Addr    = pc;
  assign PC_Rd      = pc_rd;
  assign D_Addr     = ctrl.d_addr;
  assign D_wr       = ctrl.d_wr;
  assign RF_s       = ctrl.rf_s;
  assign RF_W_addr  = ctrl.rf_w_addr;
  assign RF_W_en    = ctrl.rf_w_en;
  assign RF_Ra_addr = ctrl.rf_ra_addr;
  assign RF_Rb_addr = ctrl.rf_rb_addr;
  assign Alu_s0     = ctrl.alu_s;
  assign IR_Out     = ir;
  assign State_Out  = STATE_WIDTH'(state);
  assign Halted     = (state == S_HALT);

  // A memory store and a register write never coincide
  a_no_dual_write: assert property (@(posedge Clk) disable iff (!ResetN) !(D_wr && RF_W_en));

endmodule
